// File: rtl/seq_det_pkg.sv
// Shared types and default constants for the serial pattern detector.
//   ctrl_state_t : controller FSM states
//   DefLen       : default pattern length in bits
//   DefCw        : default width of the match counter and target
//   DefPattern   : default pattern, MSB is the first-received bit
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } ctrl_state_t;

  localparam int unsigned DefLen = 4;
  localparam int unsigned DefCw  = 8;

  localparam logic [DefLen-1:0] DefPattern = 4'b1001;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Control/data bundle for seq_detect_ctrl.
//   master : drives start/stop, pattern/target and the qualified serial bit
//   slave  : the detector; returns busy, match pulse, match count and done
interface seq_detect_ctrl_if
  import seq_det_pkg::*;
#(
  parameter int unsigned LEN = DefLen,
  parameter int unsigned CW  = DefCw
);

  logic           start;
  logic           stop;
  logic [LEN-1:0] pattern_i;
  logic [CW-1:0]  target_i;
  logic           in_valid;
  logic           in;
  logic           busy;
  logic           match;
  logic [CW-1:0]  match_cnt;
  logic           done;

  modport master (
    output start, stop, pattern_i, target_i, in_valid, in,
    input  busy, match, match_cnt, done
  );

  modport slave (
    input  start, stop, pattern_i, target_i, in_valid, in,
    output busy, match, match_cnt, done
  );

endinterface

// File: rtl/seq_window.sv
// History shift register, fill counter and pattern comparator.
//   clk, rst  : clock, asynchronous active-high reset
//   clear_i   : empty the window (accepted start)
//   shift_i   : accept bit_i into the window (newest bit at the LSB)
//   bit_i     : serial data bit
//   pattern_i : latched target pattern
//   hit_o     : combinational; the bit being accepted completes a match
// Build option: SEQ_DETECT_OVERLAP_EN keeps window and fill after a match so
// overlapping occurrences are counted; otherwise the fill restarts from 0.
module seq_window
  import seq_det_pkg::*;
#(
  parameter int unsigned LEN = DefLen
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear_i,
  input  logic           shift_i,
  input  logic           bit_i,
  input  logic [LEN-1:0] pattern_i,
  output logic           hit_o
);

  localparam int unsigned FW = $clog2(LEN + 1);
  localparam logic [FW-1:0] FillMax = FW'(LEN);
  // Fill value at which the incoming bit makes the window complete.
  localparam logic [FW-1:0] FillArm = FW'(LEN - 1);

  logic [LEN-1:0] window_q, window_d;
  logic [FW-1:0]  fill_q, fill_d;

  always_comb begin
    window_d = {window_q[LEN-2:0], bit_i};
    fill_d   = (fill_q == FillMax) ? fill_q : fill_q + 1'b1;
    hit_o    = shift_i && (fill_q >= FillArm) && (window_d == pattern_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_q <= '0;
      fill_q   <= '0;
    end else if (clear_i) begin
      window_q <= '0;
      fill_q   <= '0;
    end else if (shift_i) begin
      window_q <= window_d;
`ifdef SEQ_DETECT_OVERLAP_EN
      fill_q   <= fill_d;
`else
      fill_q   <= hit_o ? '0 : fill_d;
`endif
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector with arm/abort control and a match counter.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seq_detect_ctrl_if slave modport
//              start/stop        arm (IDLE only) / abort (ARMED, has priority)
//              pattern_i/target_i latched on accepted start; target 0 = unlimited
//              in_valid/in       qualified serial bit
//              busy/done         state == ARMED / state == DONE
//              match/match_cnt   registered pulse per match / matches since start
// Build option: SEQ_DETECT_OVERLAP_EN (see seq_window) enables overlapping matches.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned LEN = DefLen,
  parameter int unsigned CW  = DefCw
) (
  input logic              clk,
  input logic              rst,
  seq_detect_ctrl_if.slave bus
);

  ctrl_state_t    state_q;
  logic [LEN-1:0] pattern_q;
  logic [CW-1:0]  target_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, match_q, done_q;

  logic accept_start, accept_bit, hit;

  always_comb begin
    accept_start = (state_q == IDLE) && bus.start && !bus.stop;
    accept_bit   = (state_q == ARMED) && bus.in_valid && !bus.stop;
    // Saturates at all-ones; only reachable with an unlimited target.
    cnt_d        = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  end

  seq_window #(
    .LEN (LEN)
  ) u_window (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (accept_start),
    .shift_i   (accept_bit),
    .bit_i     (bus.in),
    .pattern_i (pattern_q),
    .hit_o     (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      target_q  <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      match_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      match_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept_start) begin
            state_q   <= ARMED;
            busy_q    <= 1'b1;
            pattern_q <= bus.pattern_i;
            target_q  <= bus.target_i;
            cnt_q     <= '0;
          end
        end
        ARMED: begin
          if (bus.stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (hit) begin
            match_q <= 1'b1;
            cnt_q   <= cnt_d;
            if ((target_q != '0) && (cnt_d == target_q)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl; outputs sampled 1 time unit after each rising edge.
module tb_seq_detect_ctrl;
  import seq_det_pkg::*;

  localparam int unsigned LEN = DefLen;
  localparam int unsigned CW  = DefCw;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [CW-1:0] exp_cnt;
  logic          exp_m;

  seq_detect_ctrl_if #(.LEN(LEN), .CW(CW)) bus ();

  seq_detect_ctrl #(.LEN(LEN), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic b, input logic m, input logic d,
                         input logic [CW-1:0] c);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    chk({tag, ".match"}, 32'(bus.match), 32'(m));
    chk({tag, ".done"}, 32'(bus.done), 32'(d));
    chk({tag, ".cnt"}, 32'(bus.match_cnt), 32'(c));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic b);
    bus.in_valid = 1'b1;
    bus.in       = b;
    cycle();
    bus.in_valid = 1'b0;
    bus.in       = 1'b0;
  endtask

  // Invalid cycle carrying in=1; must not enter the window.
  task automatic gap();
    bus.in_valid = 1'b0;
    bus.in       = 1'b1;
    cycle();
    bus.in       = 1'b0;
  endtask

  task automatic arm(input logic [LEN-1:0] pat, input logic [CW-1:0] tgt);
    bus.start     = 1'b1;
    bus.pattern_i = pat;
    bus.target_i  = tgt;
    cycle();
    bus.start     = 1'b0;
    bus.pattern_i = '0;
    bus.target_i  = '0;
  endtask

  task automatic abort();
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.pattern_i = '0;
    bus.target_i  = '0;
    bus.in_valid  = 1'b0;
    bus.in        = 1'b0;

    // Reset values visible before any clock edge
    #1 rst = 1'b1;
    #2 chk_out("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    cycle();
    rst = 1'b0;
    cycle();
    chk_out("idle", 1'b0, 1'b0, 1'b0, 8'd0);

    // Single match with target 1
    arm(4'b1001, 8'd1);
    chk_out("s1.arm", 1'b1, 1'b0, 1'b0, 8'd0);
    feed(1'b1); feed(1'b0); feed(1'b0);
    chk_out("s1.partial", 1'b1, 1'b0, 1'b0, 8'd0);
    feed(1'b1);
    chk_out("s1.hit", 1'b0, 1'b1, 1'b1, 8'd1);
    cycle();
    chk_out("s1.after", 1'b0, 1'b0, 1'b0, 8'd1);

    // Unlimited target, stream 1001001
    arm(4'b1001, 8'd0);
    chk_out("s2.arm", 1'b1, 1'b0, 1'b0, 8'd0);
    feed(1'b1); feed(1'b0); feed(1'b0); feed(1'b1);
    chk_out("s2.first", 1'b1, 1'b1, 1'b0, 8'd1);
    feed(1'b0); feed(1'b0); feed(1'b1);
`ifdef SEQ_DETECT_OVERLAP_EN
    exp_cnt = 8'd2;
    exp_m   = 1'b1;
`else
    exp_cnt = 8'd1;
    exp_m   = 1'b0;
`endif
    chk_out("s2.second", 1'b1, exp_m, 1'b0, exp_cnt);
    abort();
    chk_out("s2.stop", 1'b0, 1'b0, 1'b0, exp_cnt);

    // Target 2 with invalid gap cycles carrying in=1
    arm(4'b1001, 8'd2);
    feed(1'b1); gap(); feed(1'b0); gap(); feed(1'b0); gap(); feed(1'b1);
    chk_out("s3.hit", 1'b1, 1'b1, 1'b0, 8'd1);
    gap();
    chk_out("s3.gap", 1'b1, 1'b0, 1'b0, 8'd1);
    abort();

    // Asynchronous reset mid-cycle while ARMED
    arm(4'b1001, 8'd0);
    feed(1'b1); feed(1'b0); feed(1'b0); feed(1'b1);
    feed(1'b1); feed(1'b0); feed(1'b0);
    chk_out("s4.pre", 1'b1, 1'b0, 1'b0, 8'd1);
    rst = 1'b1;
    #2 chk_out("s4.rst", 1'b0, 1'b0, 1'b0, 8'd0);
    cycle();
    rst = 1'b0;
    cycle();
    chk_out("s4.idle", 1'b0, 1'b0, 1'b0, 8'd0);
    arm(4'b1001, 8'd0);
    feed(1'b1);
    chk_out("s4.post", 1'b1, 1'b0, 1'b0, 8'd0);
    abort();

    // start together with stop in IDLE is refused
    bus.start     = 1'b1;
    bus.stop      = 1'b1;
    bus.pattern_i = 4'b1001;
    bus.target_i  = 8'd1;
    cycle();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk_out("s5.refused", 1'b0, 1'b0, 1'b0, 8'd0);

    // stop together with the completing bit
    arm(4'b1001, 8'd1);
    feed(1'b1); feed(1'b0); feed(1'b0);
    bus.in_valid = 1'b1;
    bus.in       = 1'b1;
    bus.stop     = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    bus.in       = 1'b0;
    bus.stop     = 1'b0;
    chk_out("s5.stop", 1'b0, 1'b0, 1'b0, 8'd0);
    cycle();
    chk_out("s5.idle", 1'b0, 1'b0, 1'b0, 8'd0);

    // start while ARMED and while DONE is ignored
    arm(4'b1001, 8'd1);
    feed(1'b1);
    bus.start     = 1'b1;
    bus.pattern_i = 4'b1111;
    bus.target_i  = 8'd3;
    cycle();
    bus.start = 1'b0;
    chk_out("s6.ignored", 1'b1, 1'b0, 1'b0, 8'd0);
    feed(1'b0); feed(1'b0); feed(1'b1);
    chk_out("s6.hit", 1'b0, 1'b1, 1'b1, 8'd1);
    bus.start    = 1'b1;
    bus.target_i = 8'd5;
    cycle();
    bus.start = 1'b0;
    chk_out("s6.done_start", 1'b0, 1'b0, 1'b0, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 The block SHALL have parameter LEN, default 4, giving the pattern length in bits (LEN >= 2).
REQ-002 The block SHALL have parameter CW, default 8, giving the width of the match counter and target.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: arm request, sampled in IDLE only.
REQ-006 The block SHALL have port stop, input, 1 bit: abort request, sampled in ARMED.
REQ-007 The block SHALL have port pattern_i, input, LEN bits: target pattern, with MSB as the first-received bit, latched on accepted start.
REQ-008 The block SHALL have port target_i, input, CW bits: number of matches to finish, latched on accepted start; 0 means unlimited.
REQ-009 The block SHALL have port in_valid, input, 1 bit: qualifies the serial bit.
REQ-010 The block SHALL have port in, input, 1 bit: the serial data bit.
REQ-011 The block SHALL have port busy, output, 1 bit: high while state == ARMED.
REQ-012 The block SHALL have port match, output, 1 bit, registered: a one-cycle pulse per counted match.
REQ-013 The block SHALL have port match_cnt, output, CW bits, registered: matches counted since the last accepted start.
REQ-014 The block SHALL have port done, output, 1 bit: high while state == DONE (exactly one cycle).

Function
REQ-015 The FSM SHALL have states IDLE, ARMED and DONE, with transitions defined below.
- IDLE->ARMED: start=1 and stop=0.
- ARMED->IDLE: stop=1.
- ARMED->DONE: a counted match makes match_cnt equal target_q (target_q != 0).
- DONE->IDLE: unconditionally on the next edge.
REQ-016 An accepted start SHALL latch pattern_i and target_i into pattern_q and target_q, and SHALL clear match_cnt, the history window and the fill counter.
REQ-017 A bit SHALL be accepted only when state == ARMED, in_valid == 1 and stop == 0; otherwise the history is unchanged.
REQ-018 An accepted bit SHALL shift into the history window (newest bit at the LSB) and increment the fill counter, which saturates at LEN.
REQ-019 A match SHALL be detected on an accepted bit when the fill counter, including this bit, is >= LEN and the updated window equals pattern_q.
REQ-020 A detected match SHALL set match=1 in the cycle following the accepting edge and increment match_cnt at that same edge.
REQ-021 When target_q == 0, match_cnt SHALL saturate at all-ones and match SHALL still pulse on every detected match.
REQ-022 When the completing match occurs, done and match SHALL be high in the same cycle, and match_cnt SHALL hold its value until the next accepted start.
REQ-023 stop SHALL have priority over start and over bit acceptance: a bit presented together with stop is discarded, and no done is produced.
REQ-024 start asserted in ARMED or DONE SHALL be ignored, with no relatch.
REQ-025 match SHALL be 0 in every cycle not defined above.

Reset
REQ-026 While rst=1, regardless of clk, the block SHALL hold the following values:
- state = IDLE;
- busy = 0, match = 0, done = 0;
- match_cnt = 0;
- pattern_q, target_q, window and fill counter = 0.
REQ-027 A reset asserted mid-ARMED SHALL abandon any partial match, with no done pulse.

Configuration
REQ-028 The macro SEQ_DETECT_OVERLAP_EN SHALL control match overlap as follows.
- Defined: after a match, window and fill counter are retained, so overlapping matches are counted.
- Undefined: after a match, the fill counter clears to 0, so the next match needs LEN fresh accepted bits.

Structure
REQ-029 The shared package seq_det_pkg SHALL hold the FSM enum typedef ctrl_state_t {IDLE, ARMED, DONE} and the default constants for LEN (4), CW (8) and the default pattern 4'b1001.
REQ-030 The history shift register, fill counter and comparator SHALL be placed in the sub-module seq_window, instanced once; the FSM and the counters stay in seq_detect_ctrl.

Verification
REQ-031 The bench SHALL cover the scenarios below.
- Pattern 1001, target 1, in 1,0,0,1 on consecutive valid cycles -> match=1, done=1 and match_cnt=1 in the cycle after the 4th bit; IDLE the following cycle.
- Pattern 1001, target 0, stream 1001001 -> match_cnt=2 with SEQ_DETECT_OVERLAP_EN; match_cnt=1 without it.
- Pattern 1001, target 2, stream 1,0,0,1 with in_valid=0 cycles inserted carrying in=1 -> the gap bits are ignored and match_cnt=1, busy stays 1.
- rst pulse mid-cycle while ARMED after bits 1,0,0 -> outputs zero immediately; after release, start then 1 alone gives no match.
- stop asserted together with the completing 4th bit -> no match, no done, IDLE next cycle, match_cnt unchanged.
- start pulse while ARMED with pattern_i=1111 -> ignored; the original pattern 1001 still matches.
